// File: rtl/accum_seq_pkg.sv
// Shared types and constants for the accumulator sequencer.
// Instruction word layout: {chain, m, a, b}, LSB first b.
package accum_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND = 4'b0011;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_INC = 4'b0110;

    function automatic int f_b_lsb(input int dw);
        return 0 * dw;
    endfunction

    function automatic int f_a_lsb(input int dw);
        return dw;
    endfunction

    function automatic int f_m_lsb(input int dw);
        return 2 * dw;
    endfunction

    function automatic int f_chain_bit(input int dw);
        return 2 * dw + OP_W;
    endfunction

    function automatic int f_instr_w(input int dw);
        return 2 * dw + OP_W + 1;
    endfunction

endpackage

// File: rtl/accum_seq_imem.sv
// Program store: register file with one write port and one async read port.
// Contents clear to zero on reset.
module accum_seq_imem #(
    parameter int DEPTH = 8,
    parameter int W     = 13,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          nReset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/accum_seq.sv
// Accumulator sequencer: steps a stored program through an external ALU.
// Optional SEQ_CHAIN_EN: chain=1 feeds the last result into operand a.
module accum_seq
    import accum_seq_pkg::*;
#(
    parameter int PROG_DEPTH = 8,
    parameter int DATA_W     = 4,
    localparam int AW        = $clog2(PROG_DEPTH),
    localparam int IW        = f_instr_w(DATA_W)
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              start,
    input  logic [AW-1:0]     len,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [IW-1:0]     prog_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_m,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_of,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              of_sticky,
    output logic [AW-1:0]     pc
);

    localparam int B_LSB = f_b_lsb(DATA_W);
    localparam int A_LSB = f_a_lsb(DATA_W);
    localparam int M_LSB = f_m_lsb(DATA_W);
    localparam int C_BIT = f_chain_bit(DATA_W);

    state_t              r_state;
    state_t              w_next;
    logic [AW-1:0]       r_len;
    logic [AW-1:0]       r_pc;
    logic [DATA_W-1:0]   r_result;
    logic                r_of;
    logic                r_done;
    logic [IW-1:0]       w_instr;
    logic [DATA_W-1:0]   w_a_src;
    logic                w_we;
    logic                w_active;

    // Writes only land while idle, so a running program is never disturbed.
    assign w_we = prog_we && (r_state == S_IDLE);

    accum_seq_imem #(
        .DEPTH (PROG_DEPTH),
        .W     (IW)
    ) u_imem (
        .Clk     (Clk),
        .nReset  (nReset),
        .i_we    (w_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (r_pc),
        .o_rdata (w_instr)
    );

`ifdef SEQ_CHAIN_EN
    assign w_a_src = w_instr[C_BIT] ? r_result
                                    : w_instr[A_LSB +: DATA_W];
`else
    logic w_unused_chain;
    assign w_unused_chain = w_instr[C_BIT];
    assign w_a_src        = w_instr[A_LSB +: DATA_W];
`endif

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    w_next = start ? S_ISSUE : S_IDLE;
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = (r_pc == r_len) ? S_DONE : S_ISSUE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_active = (r_state == S_ISSUE) || (r_state == S_CAPTURE);
        alu_m    = '0;
        alu_a    = '0;
        alu_b    = '0;
        if (w_active) begin
            alu_m = w_instr[M_LSB +: OP_W];
            alu_a = w_a_src;
            alu_b = w_instr[B_LSB +: DATA_W];
        end
        busy = w_active;
    end

    // done is registered off the DONE state, so it lands one cycle later.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_len    <= '0;
            r_pc     <= '0;
            r_result <= '0;
            r_of     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
            if (r_state == S_IDLE && start) begin
                r_len    <= len;
                r_pc     <= '0;
                r_result <= '0;
                r_of     <= 1'b0;
            end else if (r_state == S_CAPTURE) begin
                r_result <= alu_r;
                r_of     <= r_of | alu_of;
                if (r_pc != r_len) begin
                    r_pc <= r_pc + 1'b1;
                end
            end
        end
    end

    assign alu_cin   = 1'b0;
    assign done      = r_done;
    assign result    = r_result;
    assign of_sticky = r_of;
    assign pc        = r_pc;

endmodule

// File: tb/tb_accum_seq.sv
// Directed bench for accum_seq with a registered ALU model.
// Expected values are hand-computed per directed step.
module tb_accum_seq;
    import accum_seq_pkg::*;

    logic        Clk = 1'b0;
    logic        nReset;
    logic        start;
    logic [2:0]  len;
    logic        prog_we;
    logic [2:0]  prog_addr;
    logic [12:0] prog_data;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_m;
    logic        alu_cin;
    logic [3:0]  alu_r;
    logic        alu_of;
    logic        busy;
    logic        done;
    logic [3:0]  result;
    logic        of_sticky;
    logic [2:0]  pc;

    int tests = 0;
    int fails = 0;

    accum_seq dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .start     (start),
        .len       (len),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_m     (alu_m),
        .alu_cin   (alu_cin),
        .alu_r     (alu_r),
        .alu_of    (alu_of),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .of_sticky (of_sticky),
        .pc        (pc)
    );

    always #5 Clk = ~Clk;

    // External ALU: result and carry/borrow registered on each edge.
    logic [4:0] w_alu;
    always_comb begin
        w_alu = '0;
        case (alu_m)
            OP_ADD:  w_alu = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  w_alu = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND:  w_alu = {1'b0, alu_a & alu_b};
            OP_OR:   w_alu = {1'b0, alu_a | alu_b};
            OP_INC:  w_alu = {1'b0, alu_a} + 5'd1;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            {alu_of, alu_r} <= '0;
        end else begin
            {alu_of, alu_r} <= w_alu;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] ins(input logic c, input logic [3:0] m,
                                        input logic [3:0] a,
                                        input logic [3:0] b);
        return {c, m, a, b};
    endfunction

    task automatic prog(input logic [2:0] addr, input logic [12:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    // Start a run; n = edges after start edge until done seen (-1 if never).
    task automatic run(input logic [2:0] l, input int p1, input int p2,
                       input int we_at, input logic [12:0] wd,
                       output int n, output int nd,
                       output logic [11:0] op0);
        start = 1'b1;
        len   = l;
        if (we_at == 0) begin
            prog_we   = 1'b1;
            prog_addr = 3'd0;
            prog_data = wd;
        end
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        op0     = {alu_m, alu_a, alu_b};
        n       = -1;
        nd      = 0;
        for (int c = 1; c <= 60; c++) begin
            start     = (c == p1) || (c == p2);
            prog_we   = (c == we_at);
            prog_addr = 3'd0;
            prog_data = wd;
            tick();
            if (done) begin
                nd++;
                if (n < 0) n = c;
            end
        end
        start   = 1'b0;
        prog_we = 1'b0;
    endtask

    initial begin
        int          n;
        int          nd;
        int          dcnt;
        logic [11:0] op0;
        logic [3:0]  exp_chain;

        nReset    = 1'b0;
        start     = 1'b0;
        len       = '0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        tick();
        tick();
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_result", 16'(result), 16'h0);
        chk("rst_of", 16'(of_sticky), 16'h0);
        chk("rst_pc", 16'(pc), 16'h0);
        chk("rst_alu", 16'({alu_cin, alu_m, alu_a, alu_b}), 16'h0);
        nReset = 1'b1;
        tick();

        // Single ADD, len=0.
        prog(3'd0, ins(1'b0, OP_ADD, 4'b1010, 4'b0101));
        run(3'd0, -1, -1, -1, '0, n, nd, op0);
        chk("t1_issue_ops", 16'(op0), 16'h0A5);
        chk("t1_latency", 16'(n), 16'd3);
        chk("t1_result", 16'(result), 16'hF);
        chk("t1_of", 16'(of_sticky), 16'h0);
        chk("t1_ndone", 16'(nd), 16'd1);
        chk("idle_alu", 16'({alu_m, alu_a, alu_b}), 16'h0);

        // ADD with carry, then AND -> 0, sticky overflow.
        prog(3'd0, ins(1'b0, OP_ADD, 4'b1111, 4'b0001));
        prog(3'd1, ins(1'b0, OP_AND, 4'b1010, 4'b0101));
        run(3'd1, -1, -1, -1, '0, n, nd, op0);
        chk("t2_latency", 16'(n), 16'd5);
        chk("t2_result", 16'(result), 16'h0);
        chk("t2_of", 16'(of_sticky), 16'h1);
        chk("t2_pc", 16'(pc), 16'd1);

        // Chain: 1+1=2, then a=result (2)+2 or a-field (5)+2.
        prog(3'd0, ins(1'b0, OP_ADD, 4'b0001, 4'b0001));
        prog(3'd1, ins(1'b1, OP_ADD, 4'b0101, 4'b0010));
        run(3'd1, -1, -1, -1, '0, n, nd, op0);
`ifdef SEQ_CHAIN_EN
        exp_chain = 4'b0100;
`else
        exp_chain = 4'b0111;
`endif
        chk("t3_chain", 16'(result), 16'(exp_chain));

        // Write and start on the same edge: run uses the new word.
        run(3'd0, -1, -1, 0, ins(1'b0, OP_OR, 4'b1000, 4'b0001),
            n, nd, op0);
        chk("t4_wr_first_op", 16'(op0), 16'h481);
        chk("t4_wr_first", 16'(result), 16'h9);

        // len=7 with start pokes while busy and while in DONE.
        for (int k = 0; k < 8; k++) begin
            prog(3'(k), ins(1'b0, OP_ADD, 4'(k), 4'b0001));
        end
        run(3'd7, 5, 17, -1, '0, n, nd, op0);
        chk("t5_latency", 16'(n), 16'd17);
        chk("t5_ndone", 16'(nd), 16'd1);
        chk("t5_result", 16'(result), 16'h8);
        chk("t5_pc", 16'(pc), 16'd7);
        chk("t5_of", 16'(of_sticky), 16'h0);

        // Write while busy is dropped; rerun matches.
        prog(3'd0, ins(1'b0, OP_ADD, 4'b0011, 4'b0100));
        run(3'd0, -1, -1, 1, 13'h1FFF, n, nd, op0);
        chk("t6_run1", 16'(result), 16'h7);
        run(3'd0, -1, -1, -1, '0, n, nd, op0);
        chk("t6_run2", 16'(result), 16'h7);
        chk("t6_run2_op", 16'(op0), 16'h034);

        // Reset mid-run at cycle 5.
        start = 1'b1;
        len   = 3'd7;
        tick();
        start = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        chk("t7_pre_busy", 16'(busy), 16'h1);
        chk("t7_pre_result", 16'(result), 16'h2);
        nReset = 1'b0;
        #1;
        chk("t7_busy", 16'(busy), 16'h0);
        chk("t7_pc", 16'(pc), 16'h0);
        chk("t7_result", 16'(result), 16'h0);
        dcnt = 0;
        tick();
        if (done) dcnt++;
        tick();
        if (done) dcnt++;
        nReset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done) dcnt++;
        end
        chk("t7_no_done", 16'(dcnt), 16'd0);

        // After reset: entry0 SUB with borrow, entry1 cleared to ADD 0+0.
        prog(3'd0, ins(1'b0, OP_SUB, 4'b0011, 4'b1001));
        run(3'd0, -1, -1, -1, '0, n, nd, op0);
        chk("t8_latency", 16'(n), 16'd3);
        chk("t8_result", 16'(result), 16'hA);
        chk("t8_of", 16'(of_sticky), 16'h1);
        run(3'd1, -1, -1, -1, '0, n, nd, op0);
        chk("t8_mem_cleared", 16'(result), 16'h0);
        chk("t8_sticky", 16'(of_sticky), 16'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
